// File: rtl/handshake_fifo_buffer_if.sv
// Handshake channel bundle for handshake_fifo_buffer: upstream (ins*) and downstream (outs*) sides.
// master = the environment driving ins/outs_ready, slave = the buffer itself.
interface handshake_fifo_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic                  outs_valid;
    logic                  outs_ready;

    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs, outs_valid
    );

    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs, outs_valid
    );
endinterface

// File: rtl/handshake_fifo_buffer.sv
// Elastic NUM_SLOTS-deep FIFO for the handshake fabric; ins_ready depends on registered count only.
// Optional zero-latency bypass when empty: define HANDSHAKE_FIFO_BYPASS_EN.
module handshake_fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    handshake_fifo_buffer_if.slave           bus,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   occupancy
);
    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_SLOTS);

    logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0]  wr_en;
    logic                  empty, full, push, pop, store, retire;

    assign empty         = (cnt_q == '0);
    assign full          = (cnt_q == FULL_CNT);
    assign bus.ins_ready = !full;
    assign push          = bus.ins_valid && !full;
    assign pop           = bus.outs_valid && bus.outs_ready;
    assign occupancy     = cnt_q;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
    // A token consumed straight through while empty is never written.
    assign bus.outs_valid = !empty || bus.ins_valid;
    assign bus.outs       = empty ? bus.ins : mem_q[rd_ptr_q];
    assign store          = push && !(empty && bus.outs_ready);
    assign retire         = pop && !empty;
`else
    assign bus.outs_valid = !empty;
    assign bus.outs       = mem_q[rd_ptr_q];
    assign store          = push;
    assign retire         = pop;
`endif

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_wr_en
        assign wr_en[gi] = store && (wr_ptr_q == PTR_W'(gi));
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // Explicit wrap so non-power-of-two depths work.
        if (store) begin
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (retire) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({store, retire})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (wr_en[i]) begin
                    mem_q[i] <= bus.ins;
                end
            end
        end
    end
endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Bench for handshake_fifo_buffer: a 4-slot and a 3-slot instance share one stimulus stream and
// are each compared every cycle against a queue-based model of the FIFO behaviour.
module tb_handshake_fifo_buffer;
    localparam int DW = 32;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] ins_v        = '0;
    logic          ins_valid_v  = 1'b0;
    logic          outs_ready_v = 1'b0;

    handshake_fifo_buffer_if #(.DATA_WIDTH(DW)) bus0 ();
    handshake_fifo_buffer_if #(.DATA_WIDTH(DW)) bus1 ();

    assign bus0.ins        = ins_v;
    assign bus0.ins_valid  = ins_valid_v;
    assign bus0.outs_ready = outs_ready_v;
    assign bus1.ins        = ins_v;
    assign bus1.ins_valid  = ins_valid_v;
    assign bus1.outs_ready = outs_ready_v;

    logic [2:0] occ0;
    logic [1:0] occ1;

    handshake_fifo_buffer #(.DATA_WIDTH(DW), .NUM_SLOTS(4)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .occupancy(occ0)
    );
    handshake_fifo_buffer #(.DATA_WIDTH(DW), .NUM_SLOTS(3)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .occupancy(occ1)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per instance.
    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];
    logic [DW-1:0] log1[$];
    bit            log_en = 1'b0;
    int            depth [2] = '{4, 3};

    function automatic int msize(int d);
        return (d == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [DW-1:0] mhead(int d);
        return (d == 0) ? mq0[0] : mq1[0];
    endfunction

    function automatic logic [DW-1:0] obs_outs(int d);
        return (d == 0) ? bus0.outs : bus1.outs;
    endfunction

    function automatic logic obs_valid(int d);
        return (d == 0) ? bus0.outs_valid : bus1.outs_valid;
    endfunction

    function automatic logic obs_ready(int d);
        return (d == 0) ? bus0.ins_ready : bus1.ins_ready;
    endfunction

    function automatic logic [DW-1:0] obs_occ(int d);
        return (d == 0) ? DW'(occ0) : DW'(occ1);
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive inputs, check all outputs against the model, clock once, advance the model.
    task automatic do_cycle(input logic v, input logic [DW-1:0] data, input logic r);
        logic          ev [2];
        logic [DW-1:0] seen [2];
        ins_v        = data;
        ins_valid_v  = v;
        outs_ready_v = r;
        #1;
        for (int d = 0; d < 2; d++) begin
            ev[d]   = (msize(d) != 0) || (BYP && v);
            seen[d] = obs_outs(d);
            check($sformatf("d%0d_outs_valid", d), DW'(obs_valid(d)), DW'(ev[d]));
            if (ev[d])
                check($sformatf("d%0d_outs", d), seen[d], (msize(d) != 0) ? mhead(d) : data);
            check($sformatf("d%0d_ins_ready", d), DW'(obs_ready(d)), DW'(msize(d) != depth[d]));
            check($sformatf("d%0d_occupancy", d), obs_occ(d), DW'(msize(d)));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            int s;
            bit push, pop;
            s    = msize(d);
            push = v && (s != depth[d]);
            pop  = ev[d] && r;
            if (d == 1 && pop && log_en) log1.push_back(seen[1]);
            if (pop && s != 0) begin
                if (d == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
            end
            if (push && !(pop && s == 0)) begin
                if (d == 0) mq0.push_back(data); else mq1.push_back(data);
            end
        end
        $display("cycle t=%0t v=%0b ins=%0d r=%0b occ0=%0d occ1=%0d", $time, v, data, r, mq0.size(), mq1.size());
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) do_cycle(1'b0, '0, 1'b1);
    endtask

    task automatic check_reset_values();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_rst_outs_valid", d), DW'(obs_valid(d)), '0);
            check($sformatf("d%0d_rst_ins_ready", d), DW'(obs_ready(d)), DW'(1));
            check($sformatf("d%0d_rst_occupancy", d), obs_occ(d), '0);
            check($sformatf("d%0d_rst_outs", d), obs_outs(d), '0);
        end
    endtask

    initial begin
        logic [DW-1:0] held;
        int            guard;

        // Power-on reset
        #1;
        check_reset_values();
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;

        // Fill to full with backpressure, refuse 5th, then pop while full
        for (int k = 1; k <= 4; k++) do_cycle(1'b1, DW'(k), 1'b0);
        do_cycle(1'b1, 5, 1'b0);
        check("full_occ0", DW'(occ0), 4);
        do_cycle(1'b1, 5, 1'b1);
        check("full_pop_occ0", DW'(occ0), 3);
        do_cycle(1'b1, 5, 1'b0);
        check("refill_occ0", DW'(occ0), 4);
        drain();

        // Asynchronous reset mid-stream
        for (int k = 13; k <= 15; k++) do_cycle(1'b1, DW'(k), 1'b0);
        ins_valid_v = 1'b0;
        ins_v       = '0;
        rst         = 1'b1;
        #1;
        check_reset_values();
        mq0.delete();
        mq1.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        do_cycle(1'b1, 7, 1'b0);
        ins_valid_v = 1'b0;
        #1;
        check("after_rst_head", bus0.outs, 7);
        do_cycle(1'b0, '0, 1'b1);
        drain();

        // Backpressure hold
        do_cycle(1'b1, 42, 1'b0);
        #1 held = bus0.outs;
        check("hold_capture", held, 42);
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, '0, 1'b0);
            check("hold_stable", bus0.outs, held);
        end
        do_cycle(1'b0, '0, 1'b1);
        drain();

        // Steady streaming
        for (int k = 100; k < 120; k++) do_cycle(1'b1, DW'(k), 1'b1);
        drain();

        // Wrap-around on the 3-slot instance with random backpressure
        log1.delete();
        log_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bit taken;
            guard = 0;
            taken = 1'b0;
            while (!taken && guard < 50) begin
                taken = (msize(1) != 3);
                do_cycle(1'b1, DW'(k), 1'($urandom_range(0, 1)));
                guard++;
            end
            if (!taken) check("wrap_push_timeout", DW'(guard), 0);
        end
        guard = 0;
        while (mq1.size() != 0 && guard < 100) begin
            do_cycle(1'b0, '0, 1'($urandom_range(0, 1)));
            guard++;
        end
        log_en = 1'b0;
        check("wrap_count", DW'(log1.size()), 10);
        for (int k = 0; k < 10 && k < log1.size(); k++)
            check($sformatf("wrap_order_%0d", k), log1[k], DW'(k));
        drain();

        // Random traffic
        for (int i = 0; i < 300; i++)
            do_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/handshake_fifo_buffer.md
# handshake_fifo_buffer

Elastic multi-slot FIFO buffer for the dataflow handshake fabric. It sits directly downstream of constant and arithmetic handshake units and consumes their `outs`/`outs_valid`/`outs_ready` channel. It decouples producer and consumer backpressure and breaks the combinational ready path. Data is delivered in strict FIFO order with no loss and no duplication.

## Interface
- `DATA_WIDTH`, default 32: width of the data token.
- `NUM_SLOTS`, default 4: storage depth. Legal range is 2 or more; any integer is allowed, not only powers of two.
- `clk` input 1: rising-edge clock. The block has one clock.
- `rst` input 1: reset. Asynchronous, active-high.
- `ins` input DATA_WIDTH: upstream data token.
- `ins_valid` input 1: upstream token valid.
- `ins_ready` output 1: buffer can accept a token.
- `outs` output DATA_WIDTH: head token.
- `outs_valid` output 1: head token valid.
- `outs_ready` input 1: downstream accepts the head token.
- `occupancy` output $clog2(NUM_SLOTS+1): number of stored tokens.

## Operation
- **Storage:** a register array `mem[NUM_SLOTS]`, a write pointer `wr_ptr`, a read pointer `rd_ptr`, and a count `cnt`. Both pointers wrap from NUM_SLOTS-1 to 0 by explicit compare, not by modulo-2^n.
- **Push:** `ins_valid && ins_ready`. Writes `mem[wr_ptr]`, then increments `wr_ptr`.
- **Pop:** `outs_valid && outs_ready`. Increments `rd_ptr`.
- **Count:** `cnt` changes by +1 on push only, −1 on pop only, and 0 on both or neither.
- **`ins_ready`:** equals `cnt != NUM_SLOTS`.
  - It depends only on registered state.
  - There is no combinational path from `outs_ready` to `ins_ready`.
  - When full with a pop this cycle, the input is still refused. It is accepted next cycle.
- **`outs_valid`:** equals `cnt != 0`. `outs` equals `mem[rd_ptr]`.
- **Empty:** `outs_valid` is 0. `outs` shows the stale slot and carries no meaning.
- **`occupancy`:** equals `cnt`.
- **States:** the state is implied by `cnt`.
  - EMPTY (cnt=0): push only → PARTIAL, or → FULL when NUM_SLOTS=1 is disallowed.
  - PARTIAL: push only → cnt+1, reaching FULL at NUM_SLOTS. Pop only → cnt−1, reaching EMPTY at 0. Push and pop → unchanged.
  - FULL: pop → PARTIAL. Push is impossible.
- **Reset:** asserting `rst` at any time, including mid-transfer, immediately clears `wr_ptr`, `rd_ptr` and `cnt` to 0. Tokens in flight are discarded. `mem` is cleared to 0.

## Timing
- Reset values:
  - `outs_valid` = 0
  - `ins_ready` = 1
  - `occupancy` = 0
  - `outs` = 0
- First cycle after `rst` deasserts: a push is accepted.
- Latency without bypass: a token pushed at edge N is visible on `outs` with `outs_valid`=1 in the cycle after edge N. Minimum latency is 1 cycle.
- Throughput: 1 token/cycle in steady state with simultaneous push and pop.
- `outs`/`outs_valid` hold stable while `outs_valid`=1 and `outs_ready`=0. This is the valid-hold rule.
- The block imposes no requirement on upstream holding `ins`.

## Configuration
- Macro: `HANDSHAKE_FIFO_BYPASS_EN`.
- **Defined:** when `cnt`=0, the block drives `outs_valid` = `ins_valid` and `outs` = `ins` combinationally.
  - If `outs_ready`=1 in that cycle, the token passes with zero latency, is not written, and `cnt` stays 0.
  - If `outs_ready`=0, the token is written normally.
  - `ins_ready` is unchanged, so it still has no combinational path from `outs_ready`.
- **Undefined:** no bypass. Minimum latency is 1 cycle. `outs` is purely registered.

## Test plan
- Reset mid-stream: fill 3 tokens (13, 14, 15), assert `rst` for 1 cycle → `outs_valid`=0, `occupancy`=0, `ins_ready`=1 immediately. The next push of 7 is the next output.
- Fill to full with `outs_ready`=0: push 1, 2, 3, 4 with NUM_SLOTS=4 → `ins_ready`=0 and `occupancy`=4. A 5th `ins_valid` is refused and `outs` holds 1.
- Full with simultaneous pop: in a FULL cycle, `outs_ready`=1 and `ins_valid`=1 → 1 is popped and the input is not taken (`occupancy`=3). The input is accepted next cycle and `occupancy` returns to 4.
- Wrap-around with NUM_SLOTS=3: stream 10 tokens 0..9 with random `outs_ready` → output order is 0..9 exactly and the pointers wrap at 2→0.
- Steady streaming: `ins_valid`=`outs_ready`=1 for 20 cycles with values 100..119 → one token out per cycle after 1-cycle latency. With `HANDSHAKE_FIFO_BYPASS_EN` defined, the latency is 0 and `occupancy` stays 0.
- Backpressure hold: `outs_valid`=1 and `outs_ready`=0 for 5 cycles → `outs` is stable at the same value. On release, the next pop gives that value.
